// File: rtl/trace_packer_if.sv
// Bus bundle for trace_packer: sample input, trace-memory store/load ports and stream output.
// The master modport is the packer itself, the slave modport is its environment.
interface trace_packer_if #(
  parameter int TRB_WIDTH       = 64,
  parameter int TRB_MAX_TRACES  = 8,
  parameter int TRB_NTRACE_BITS = 2
);
  localparam int POS_W = $clog2(TRB_WIDTH);

  logic                       MODE_I;
  logic [TRB_NTRACE_BITS-1:0] NTRACE_I;
  logic [TRB_MAX_TRACES-1:0]  TRACE_I;
  logic                       TRACE_VALID_I;
  logic                       TRIGGER_I;
  logic                       TRG_EVENT_O;
  logic [POS_W-1:0]           EVENT_POS_O;
  logic                       TRG_DELAYED_I;
  logic [TRB_WIDTH-1:0]       DATA_O;
  logic                       STORE_O;
  logic                       STORE_PERM_I;
  logic [TRB_WIDTH-1:0]       DATA_I;
  logic                       LOAD_REQUEST_O;
  logic                       LOAD_GRANT_I;
  logic [TRB_MAX_TRACES-1:0]  TRACE_O;
  logic                       TRACE_VALID_O;
  logic                       TRACE_READY_I;
  logic                       OVERFLOW_O;

  modport master (
    input  MODE_I, NTRACE_I, TRACE_I, TRACE_VALID_I, TRIGGER_I, TRG_DELAYED_I,
           STORE_PERM_I, DATA_I, LOAD_GRANT_I, TRACE_READY_I,
    output TRG_EVENT_O, EVENT_POS_O, DATA_O, STORE_O, LOAD_REQUEST_O,
           TRACE_O, TRACE_VALID_O, OVERFLOW_O
  );

  modport slave (
    output MODE_I, NTRACE_I, TRACE_I, TRACE_VALID_I, TRIGGER_I, TRG_DELAYED_I,
           STORE_PERM_I, DATA_I, LOAD_GRANT_I, TRACE_READY_I,
    input  TRG_EVENT_O, EVENT_POS_O, DATA_O, STORE_O, LOAD_REQUEST_O,
           TRACE_O, TRACE_VALID_O, OVERFLOW_O
  );
endinterface

// File: rtl/trace_packer.sv
// Trace packer: packs per-cycle trace lanes into memory words (trace mode) or
// fetches memory words and unpacks them onto the trace lanes (streaming mode).
module trace_packer #(
  parameter int TRB_WIDTH       = 64,
  parameter int TRB_MAX_TRACES  = 8,
  parameter int TRB_NTRACE_BITS = 2
) (
  input logic            CLK_I,
  input logic            RST_I,
  trace_packer_if.master bus
);
  localparam int POS_W  = $clog2(TRB_WIDTH);
  localparam int FILL_W = POS_W + 1;
  localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(TRB_WIDTH);

  typedef enum logic [1:0] {ST_CAPTURE = 2'd0, ST_HALT = 2'd1, ST_STREAM = 2'd2} state_e;
  typedef enum logic [1:0] {LD_EMPTY = 2'd0, LD_REQ = 2'd1, LD_WAIT = 2'd2, LD_FULL = 2'd3} load_e;

  state_e                     state_r, state_s;
  load_e                      ld_r, ld_s;
  logic [TRB_NTRACE_BITS-1:0] ntrace_r;
  logic [FILL_W-1:0]          lanes_s;
  logic [TRB_MAX_TRACES-1:0]  lane_mask_s;
  logic [TRB_WIDTH-1:0]       pack_r, pack_s, shadow_r, shadow_s, word_r, word_s;
  logic [TRB_WIDTH-1:0]       sample_word_s;
  logic [FILL_W-1:0]          fill_r, fill_s, pos_r, pos_s;
  logic                       shadow_full_r, shadow_full_s, store_r, store_s;
  logic                       trg_r, trg_s, overflow_r, overflow_s;
  logic [POS_W-1:0]           event_pos_r, event_pos_s;
  logic                       req_r, tvalid_r;
  logic [TRB_MAX_TRACES-1:0]  trace_o_r, trace_o_s;
  logic                       sample_s, move_s;

  // Lane count and mask derived from the lane code latched during reset
  always_comb begin
    lanes_s = {{(FILL_W-1){1'b0}}, 1'b1} << ntrace_r;
    for (int i = 0; i < TRB_MAX_TRACES; i++) begin
      lane_mask_s[i] = (i < int'(lanes_s));
    end
  end

  // Top-level mode FSM: capture halts for good once the trigger delay expires
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CAPTURE: if (bus.TRG_DELAYED_I) state_s = ST_HALT; else state_s = ST_CAPTURE;
      ST_HALT:    state_s = ST_HALT;
      ST_STREAM:  state_s = ST_STREAM;
      default:    state_s = ST_CAPTURE;
    endcase
  end

  // Packing, shadow hand-off, store strobe, trigger capture and overflow
  always_comb begin
    pack_s        = pack_r;
    fill_s        = fill_r;
    shadow_s      = shadow_r;
    shadow_full_s = shadow_full_r;
    store_s       = 1'b0;
    trg_s         = trg_r;
    event_pos_s   = event_pos_r;
    overflow_s    = overflow_r;
    sample_word_s = TRB_WIDTH'(bus.TRACE_I & lane_mask_s);
    sample_s      = bus.TRACE_VALID_I && (state_r == ST_CAPTURE) && !bus.TRG_DELAYED_I;
    // A full pack word, or a partial one after halt, leaves as soon as the shadow is free
    move_s        = !shadow_full_r &&
                    ((fill_r == FULL_FILL) || ((state_r == ST_HALT) && (fill_r != '0)));

    if (move_s) begin
      shadow_s      = pack_r;
      shadow_full_s = 1'b1;
      if (sample_s) begin
        pack_s = sample_word_s;
        fill_s = lanes_s;
      end else begin
        pack_s = '0;
        fill_s = '0;
      end
    end else if (sample_s && (fill_r != FULL_FILL)) begin
      pack_s = pack_r | (sample_word_s << fill_r);
      fill_s = fill_r + lanes_s;
    end else if (sample_s) begin
      overflow_s = 1'b1;
    end else begin
      pack_s = pack_r;
    end

    if (sample_s && (move_s || (fill_r != FULL_FILL)) && bus.TRIGGER_I && !trg_r) begin
      trg_s       = 1'b1;
      event_pos_s = fill_r[POS_W-1:0];
    end else begin
      trg_s = trg_r;
    end

    if (shadow_full_r && bus.STORE_PERM_I && !store_r) begin
      store_s       = 1'b1;
      shadow_full_s = 1'b0;
    end else begin
      store_s = 1'b0;
    end
  end

  // Streaming load FSM and lane unpacking
  always_comb begin
    ld_s = ld_r;
    word_s = word_r;
    pos_s = pos_r;
    case (ld_r)
      LD_EMPTY: if (state_r == ST_STREAM) ld_s = LD_REQ; else ld_s = LD_EMPTY;
      LD_REQ:   ld_s = LD_WAIT;
      LD_WAIT: begin
        if (bus.LOAD_GRANT_I) begin
          word_s = bus.DATA_I;
          pos_s  = '0;
          ld_s   = LD_FULL;
        end else begin
          ld_s = LD_WAIT;
        end
      end
      LD_FULL: begin
        if (bus.TRACE_READY_I) begin
          pos_s = pos_r + lanes_s;
          if (pos_s == FULL_FILL) ld_s = LD_EMPTY; else ld_s = LD_FULL;
        end else begin
          ld_s = LD_FULL;
        end
      end
      default: ld_s = LD_EMPTY;
    endcase
    if (ld_s == LD_FULL) begin
      trace_o_s = TRB_MAX_TRACES'(word_s >> pos_s) & lane_mask_s;
    end else begin
      trace_o_s = '0;
    end
  end

  // State and output registers; mode and lane code are only taken while in reset
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_r       <= bus.MODE_I ? ST_STREAM : ST_CAPTURE;
      ntrace_r      <= bus.NTRACE_I;
      ld_r          <= LD_EMPTY;
      pack_r        <= '0;
      fill_r        <= '0;
      shadow_r      <= '0;
      shadow_full_r <= 1'b0;
      store_r       <= 1'b0;
      trg_r         <= 1'b0;
      event_pos_r   <= '0;
      overflow_r    <= 1'b0;
      word_r        <= '0;
      pos_r         <= '0;
      req_r         <= 1'b0;
      tvalid_r      <= 1'b0;
      trace_o_r     <= '0;
    end else begin
      state_r       <= state_s;
      ld_r          <= ld_s;
      pack_r        <= pack_s;
      fill_r        <= fill_s;
      shadow_r      <= shadow_s;
      shadow_full_r <= shadow_full_s;
      store_r       <= store_s;
      trg_r         <= trg_s;
      event_pos_r   <= event_pos_s;
      overflow_r    <= overflow_s;
      word_r        <= word_s;
      pos_r         <= pos_s;
      req_r         <= (ld_s == LD_REQ);
      tvalid_r      <= (ld_s == LD_FULL);
      trace_o_r     <= trace_o_s;
    end
  end

  assign bus.DATA_O         = shadow_r;
  assign bus.STORE_O        = store_r;
  assign bus.TRG_EVENT_O    = trg_r;
  assign bus.EVENT_POS_O    = event_pos_r;
  assign bus.OVERFLOW_O     = overflow_r;
  assign bus.LOAD_REQUEST_O = req_r;
  assign bus.TRACE_VALID_O  = tvalid_r;
  assign bus.TRACE_O        = trace_o_r;
endmodule

// File: tb/tb_trace_packer.sv
// Self-checking bench for trace_packer: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a sample-queue reference model.
module tb_trace_packer;
  localparam int W = 64;
  localparam int M = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trace_packer_if bus_if ();
  trace_packer dut (.CLK_I(clk), .RST_I(rst), .bus(bus_if));

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model state
  bit          m_mode, m_halt, m_sh_has, m_store_prev, m_trg, m_ovf, m_wait, m_req;
  int          m_l, m_pos;
  logic [63:0] m_sh_val;
  logic [7:0]  m_part[$];
  logic [63:0] m_done[$];
  logic [7:0]  m_chunks[$];

  function automatic logic [7:0] lane_mask(input int l);
    return 8'((1 << l) - 1);
  endfunction

  task automatic close_word();
    logic [63:0] w = 64'd0;
    foreach (m_part[k]) w |= 64'(m_part[k]) << (k * m_l);
    m_done.push_back(w);
    m_part.delete();
  endtask

  task automatic model_update();
    bit store_now, move_now, offered, accept;
    if (rst) begin
      m_mode = bus_if.MODE_I;
      m_l = 1 << bus_if.NTRACE_I;
      m_halt = 0; m_sh_has = 0; m_store_prev = 0; m_trg = 0; m_ovf = 0;
      m_wait = 0; m_req = 0; m_pos = 0; m_sh_val = 64'd0;
      m_part.delete(); m_done.delete(); m_chunks.delete();
    end else if (!m_mode) begin
      store_now = m_sh_has && bus_if.STORE_PERM_I && !m_store_prev;
      move_now  = !m_sh_has && (m_done.size() > 0);
      offered   = !m_halt && bus_if.TRACE_VALID_I && !bus_if.TRG_DELAYED_I;
      accept    = offered && ((m_done.size() == 0) || move_now);
      if (offered && !accept) m_ovf = 1;
      if (move_now) begin
        m_sh_val = m_done.pop_front();
        m_sh_has = 1;
      end
      if (store_now) m_sh_has = 0;
      if (accept) begin
        if (bus_if.TRIGGER_I && !m_trg) begin
          m_trg = 1;
          m_pos = m_part.size() * m_l;
        end
        m_part.push_back(bus_if.TRACE_I & lane_mask(m_l));
        if (m_part.size() * m_l == W) close_word();
      end
      if (!m_halt && bus_if.TRG_DELAYED_I) begin
        m_halt = 1;
        if (m_part.size() > 0) close_word();
      end
      m_store_prev = store_now;
    end else begin
      if (m_chunks.size() > 0) begin
        if (bus_if.TRACE_READY_I) void'(m_chunks.pop_front());
      end else if (m_wait) begin
        if (bus_if.LOAD_GRANT_I) begin
          for (int k = 0; k < W / m_l; k++)
            m_chunks.push_back(8'(bus_if.DATA_I >> (k * m_l)) & lane_mask(m_l));
          m_wait = 0;
        end
      end else if (m_req) begin
        m_req = 0;
        m_wait = 1;
      end else begin
        m_req = 1;
      end
    end
  endtask

  task automatic compare_outputs();
    check_val("data_o", bus_if.DATA_O, m_sh_val);
    check_val("store_o", 64'(bus_if.STORE_O), 64'(m_store_prev));
    check_val("trg_event_o", 64'(bus_if.TRG_EVENT_O), 64'(m_trg));
    check_val("event_pos_o", 64'(bus_if.EVENT_POS_O), 64'(m_pos));
    check_val("overflow_o", 64'(bus_if.OVERFLOW_O), 64'(m_ovf));
    check_val("load_request_o", 64'(bus_if.LOAD_REQUEST_O), 64'(m_req));
    check_val("trace_valid_o", 64'(bus_if.TRACE_VALID_O), 64'(m_chunks.size() > 0));
    check_val("trace_o", 64'(bus_if.TRACE_O), (m_chunks.size() > 0) ? 64'(m_chunks[0]) : 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle_inputs();
    bus_if.TRACE_I = 8'd0; bus_if.TRACE_VALID_I = 1'b0; bus_if.TRIGGER_I = 1'b0;
    bus_if.TRG_DELAYED_I = 1'b0; bus_if.STORE_PERM_I = 1'b0; bus_if.DATA_I = 64'd0;
    bus_if.LOAD_GRANT_I = 1'b0; bus_if.TRACE_READY_I = 1'b0;
  endtask

  task automatic do_reset(input logic mode, input logic [1:0] nt);
    idle_inputs();
    bus_if.MODE_I = mode;
    bus_if.NTRACE_I = nt;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int nstore, cnt, nreq;
    logic [7:0] seen[$];
    logic [7:0] exp5 [5];
    exp5 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    bus_if.MODE_I = 1'b0;
    bus_if.NTRACE_I = 2'd0;
    idle_inputs();

    // T1: single lane, alternating pattern, one store of 0x5555...
    do_reset(1'b0, 2'd0);
    check_val("reset_data", bus_if.DATA_O, 64'd0);
    nstore = 0;
    bus_if.STORE_PERM_I = 1'b1;
    for (int i = 0; i < 70; i++) begin
      bus_if.TRACE_VALID_I = (i < 64);
      bus_if.TRACE_I = 8'((i % 2) == 0);
      step();
      if (bus_if.STORE_O) begin
        nstore++;
        check_val("t1_data", bus_if.DATA_O, 64'h5555555555555555);
      end
    end
    check_val("t1_nstore", 64'(nstore), 64'd1);

    // T2: eight lanes, trigger on third sample, later trigger ignored
    do_reset(1'b0, 2'd3);
    for (int i = 0; i < 8; i++) begin
      bus_if.TRACE_VALID_I = 1'b1;
      bus_if.TRACE_I = 8'($urandom);
      bus_if.TRIGGER_I = (i == 2) || (i == 5);
      step();
    end
    check_val("t2_trg", 64'(bus_if.TRG_EVENT_O), 64'd1);
    check_val("t2_pos", 64'(bus_if.EVENT_POS_O), 64'd16);

    // T3: store blocked with two words pending, one extra sample overflows
    do_reset(1'b0, 2'd3);
    for (int i = 0; i < 16; i++) begin
      bus_if.TRACE_VALID_I = 1'b1;
      bus_if.TRACE_I = 8'($urandom);
      step();
    end
    check_val("t3_no_ovf_yet", 64'(bus_if.OVERFLOW_O), 64'd0);
    step();
    check_val("t3_ovf", 64'(bus_if.OVERFLOW_O), 64'd1);
    idle_inputs();
    bus_if.STORE_PERM_I = 1'b1;
    nstore = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_if.STORE_O) nstore++;
    end
    check_val("t3_nstore", 64'(nstore), 64'd2);

    // T4: four lanes, five samples, halt flushes a zero-padded word
    do_reset(1'b0, 2'd2);
    for (int i = 0; i < 5; i++) begin
      bus_if.TRACE_VALID_I = 1'b1;
      bus_if.TRACE_I = 8'h0F;
      step();
    end
    bus_if.TRACE_VALID_I = 1'b1;
    bus_if.TRG_DELAYED_I = 1'b1;
    bus_if.STORE_PERM_I = 1'b1;
    nstore = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      bus_if.TRG_DELAYED_I = 1'b0;
      if (bus_if.STORE_O) begin
        nstore++;
        check_val("t4_data", bus_if.DATA_O, 64'h00000000000FFFFF);
      end
    end
    check_val("t4_nstore", 64'(nstore), 64'd1);

    // T5: streaming, two lanes, grant three cycles after the request
    do_reset(1'b1, 2'd1);
    bus_if.TRACE_READY_I = 1'b1;
    bus_if.DATA_I = 64'hE4;
    cnt = -1;
    nreq = 0;
    for (int i = 0; i < 60; i++) begin
      bus_if.LOAD_GRANT_I = (cnt == 3);
      step();
      if (bus_if.LOAD_REQUEST_O) begin
        nreq++;
        cnt = 0;
      end else if (cnt >= 0) begin
        cnt++;
      end
      if (bus_if.TRACE_VALID_O) seen.push_back(bus_if.TRACE_O);
    end
    while (seen.size() < 5) seen.push_back(8'hFF);
    for (int i = 0; i < 5; i++) check_val("t5_lane", 64'(seen[i]), 64'(exp5[i]));
    check_val("t5_nreq", 64'(nreq), 64'd2);

    // T6: reset in the middle of a word and in the middle of a load wait
    do_reset(1'b0, 2'd0);
    for (int i = 0; i < 70; i++) begin
      bus_if.TRACE_VALID_I = 1'b1;
      bus_if.TRACE_I = 8'($urandom);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t6_data", bus_if.DATA_O, 64'd0);
    check_val("t6_store", 64'(bus_if.STORE_O), 64'd0);
    idle_inputs();
    bus_if.STORE_PERM_I = 1'b1;
    nstore = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_if.STORE_O) nstore++;
    end
    check_val("t6_nstore", 64'(nstore), 64'd0);
    do_reset(1'b1, 2'd1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t6_req", 64'(bus_if.LOAD_REQUEST_O), 64'd0);
    check_val("t6_tvalid", 64'(bus_if.TRACE_VALID_O), 64'd0);
    bus_if.LOAD_GRANT_I = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // randomized traffic in both modes and all lane counts
    for (int r = 0; r < 8; r++) begin
      do_reset(1'((r % 2) == 1), 2'($urandom_range(0, 3)));
      for (int i = 0; i < 400; i++) begin
        bus_if.TRACE_I = 8'($urandom);
        bus_if.TRACE_VALID_I = ($urandom_range(0, 9) < 6);
        bus_if.TRIGGER_I = ($urandom_range(0, 19) == 0);
        bus_if.TRG_DELAYED_I = ($urandom_range(0, 299) == 0);
        bus_if.STORE_PERM_I = 1'($urandom_range(0, 1));
        bus_if.DATA_I = {$urandom, $urandom};
        bus_if.LOAD_GRANT_I = ($urandom_range(0, 3) == 0);
        bus_if.TRACE_READY_I = ($urandom_range(0, 9) < 7);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
